cfg_load_sequencer: RTL and testbench

CFG_LOAD_SEQUENCER -- requirements
Module: cfg_load_sequencer

---
 rtl/encdec_pkg.sv | 16 +
 rtl/cfg_load_sequencer.sv | 96 +++++++++
 tb/tb_cfg_load_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/encdec_pkg.sv
// Shared types and sizes for the config load sequencer.
// Holds the FSM encoding and the byte/timeout counter widths.
package encdec_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_ERROR
  } state_t;

  localparam int CFG_BYTES = 8;
  localparam int CNT_W     = 4;
  localparam int GAP_W     = 8;

endpackage

// File: rtl/cfg_load_sequencer.sv
// Loads an 8-byte config word plus XOR checksum from a byte stream
// and commits it to the config register with a one-cycle strobe.
module cfg_load_sequencer
  import encdec_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        cfg_wen,
  output logic [63:0] cfg_data_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        hold_enable
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       sum_q, sum_d;
  logic [63:0]      asm_q, asm_d;
  logic [63:0]      out_q, out_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sum_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sum_q   <= sum_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sum_d   = sum_q;
    asm_d   = asm_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          gap_d   = '0;
          sum_d   = '0;
          asm_d   = '0;
        end
      end
      S_LOAD: begin
        if (byte_valid) begin
          gap_d = '0;
          if (cnt_q == CNT_W'(CFG_BYTES)) begin
            // Output word only moves on a good checksum.
            if (byte_data == sum_q) begin
              state_d = S_COMMIT;
              out_d   = asm_q;
            end else begin
              state_d = S_ERROR;
            end
          end else begin
            asm_d[{cnt_q[2:0], 3'b000} +: 8] = byte_data;
            sum_d = sum_q ^ byte_data;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_d == GAP_W'(TIMEOUT)) state_d = S_ERROR;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign cfg_wen      = (state_q == S_COMMIT);
  assign done         = (state_q == S_COMMIT);
  assign err          = (state_q == S_ERROR);
  assign busy         = (state_q != S_IDLE);
  assign hold_enable  = busy;
  assign cfg_data_out = out_q;

endmodule

// File: tb/tb_cfg_load_sequencer.sv
// Directed bench for cfg_load_sequencer with TIMEOUT=4.
// Inputs change #1 after posedge; outputs are checked there too.
module tb_cfg_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        cfg_wen;
  logic [63:0] cfg_data_out;
  logic        busy;
  logic        done;
  logic        err;
  logic        hold_enable;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] W1 = 64'h8040201008040201;
  localparam logic [63:0] W2 = 64'h8877665544332211;

  cfg_load_sequencer #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .cfg_wen     (cfg_wen),
    .cfg_data_out(cfg_data_out),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .hold_enable (hold_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  logic [7:0] seq1 [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                           8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] seq2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                           8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    tick();
    tick();
    check("rst_wen",  64'(cfg_wen), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hold", 64'(hold_enable), 64'd0);
    check("rst_err",  64'(err), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", cfg_data_out, 64'd0);
    rst = 1'b0;

    // Good load, back-to-back bytes
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ld_busy", 64'(busy), 64'd1);
    check("ld_hold", 64'(hold_enable), 64'd1);
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1;
      byte_data  = seq1[i];
      tick();
    end
    check("ld_nowen", 64'(cfg_wen), 64'd0);
    byte_data = 8'hFF;
    tick();
    byte_valid = 1'b0;
    check("c1_wen",  64'(cfg_wen), 64'd1);
    check("c1_done", 64'(done), 64'd1);
    check("c1_data", cfg_data_out, W1);
    tick();
    check("c1_wen0",  64'(cfg_wen), 64'd0);
    check("c1_done0", 64'(done), 64'd0);
    check("c1_busy0", 64'(busy), 64'd0);
    check("c1_hold",  cfg_data_out, W1);

    // Bad checksum
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) send(seq1[i]);
    send(8'h00);
    check("bad_wen",  64'(cfg_wen), 64'd0);
    check("bad_err",  64'(err), 64'd1);
    check("bad_data", cfg_data_out, W1);
    tick();
    tick();
    check("bad_errh", 64'(err), 64'd1);
    check("bad_busy", 64'(busy), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_err",  64'(err), 64'd0);
    check("rs_busy", 64'(busy), 64'd1);

    // Timeout after 3 bytes
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    tick();
    tick();
    tick();
    check("to_pre", 64'(err), 64'd0);
    tick();
    check("to_err",  64'(err), 64'd1);
    check("to_wen",  64'(cfg_wen), 64'd0);
    check("to_data", cfg_data_out, W1);

    // Gapped load with start mid-load
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(seq2[i]);
      start = (i == 3);
      tick();
      start = 1'b0;
      tick();
    end
    check("gap_nowen", 64'(cfg_wen), 64'd0);
    check("gap_noerr", 64'(err), 64'd0);
    send(8'h88);
    check("gap_wen",  64'(cfg_wen), 64'd1);
    check("gap_data", cfg_data_out, W2);
    tick();
    check("gap_idle", 64'(busy), 64'd0);

    // Reset mid-load after byte 5
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) send(seq1[i]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_wen",  64'(cfg_wen), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_err",  64'(err), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_data", cfg_data_out, 64'd0);
    send(8'h55);
    send(8'h66);
    check("ig_busy", 64'(busy), 64'd0);
    check("ig_wen",  64'(cfg_wen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
